// File: rtl/stack_pkg.sv
// stack_pkg: op encodings, FSM state enum and per-op stack word counts for stack_engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_CALL = 2'b00,
    OP_INT  = 2'b01,
    OP_RET  = 2'b10,
    OP_RTI  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    W_HI  = 4'd1,
    W_LO  = 4'd2,
    W_FLG = 4'd3,
    R_FLG = 4'd4,
    R_LO  = 4'd5,
    R_HI  = 4'd6,
    R_CAP = 4'd7,
    FIN   = 4'd8
  } state_e;

  // Stack words moved by each op (PC is two 16-bit words, flags add one).
  localparam logic [1:0] WORDS_CALL = 2'd2;
  localparam logic [1:0] WORDS_INT  = 2'd3;
  localparam logic [1:0] WORDS_RET  = 2'd2;
  localparam logic [1:0] WORDS_RTI  = 2'd3;

  function automatic logic [1:0] op_words(input op_e op);
    case (op)
      OP_CALL: op_words = WORDS_CALL;
      OP_INT:  op_words = WORDS_INT;
      OP_RET:  op_words = WORDS_RET;
      default: op_words = WORDS_RTI;
    endcase
  endfunction

  // Pops are the ops with the top encoding bit set.
  function automatic logic op_is_pop(input op_e op);
    op_is_pop = op[1];
  endfunction

endpackage

// File: rtl/stack_engine.sv
// stack_engine: runs CALL/INT pushes and RET/RTI pops against data memory, SP descending.
// Latency: CALL 3, INT 4, RET 4, RTI 5 busy cycles; done pulses in the last one.
// Backpressure: busy holds the pipeline; req ignored unless IDLE. Macro STACK_BOUNDS_EN adds bounds fault.
module stack_engine
  import stack_pkg::*;
#(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] SP_INIT  = 20'hFFFFF,
  parameter logic [ADDR_W-1:0] SP_LIMIT = 20'h00100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [31:0]       pc_in,
  input  logic [3:0]        flags_in,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy,
  output logic              done,
  output logic [31:0]       pc_out,
  output logic              pc_valid,
  output logic [3:0]        flags_out,
  output logic              flags_valid,
  output logic [ADDR_W-1:0] sp,
  output logic              fault
);

`ifdef STACK_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [ADDR_W+1:0] ONE_X = {{(ADDR_W+1){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_next;
  op_e               r_op;
  logic [31:0]       r_pc;
  logic [3:0]        r_flags;
  logic [ADDR_W-1:0] r_sp;
  logic [31:0]       r_pc_out;
  logic [3:0]        r_flags_out;
  logic              r_skip;
  logic              r_fault;

  op_e               w_op;
  logic              w_accept;
  logic [1:0]        w_words_in;
  logic [ADDR_W-1:0] w_words;
  logic [ADDR_W+1:0] w_sp_x;
  logic [ADDR_W+1:0] w_n_x;
  logic              w_push_bad;
  logic              w_pop_bad;
  logic              w_bad;

  assign w_op       = op_e'(op);
  assign w_accept   = (r_state == IDLE) && req;
  assign w_words_in = op_words(w_op);
  assign w_words    = {{(ADDR_W-2){1'b0}}, op_words(r_op)};

  // Bounds are compared two bits wider so SP-n+1 and SP+n cannot wrap.
  assign w_sp_x     = {2'b00, r_sp};
  assign w_n_x      = {{ADDR_W{1'b0}}, w_words_in};
  assign w_push_bad = (w_sp_x + ONE_X) < ({2'b00, SP_LIMIT} + w_n_x);
  assign w_pop_bad  = (w_sp_x + w_n_x) > {2'b00, SP_INIT};
  assign w_bad      = BOUNDS_EN && (op_is_pop(w_op) ? w_pop_bad : w_push_bad);

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Latch the request on accept; an out-of-bounds op is marked to skip memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= OP_CALL;
      r_pc    <= '0;
      r_flags <= '0;
      r_skip  <= 1'b0;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_op    <= w_op;
      r_pc    <= pc_in;
      r_flags <= flags_in;
      r_skip  <= w_bad;
      if (w_bad) r_fault <= 1'b1;
    end
  end

  // SP moves once per op, in FIN, by the op's word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp <= SP_INIT;
    end else if (r_state == FIN && !r_skip) begin
      if (op_is_pop(r_op)) r_sp <= r_sp + w_words;
      else                 r_sp <= r_sp - w_words;
    end
  end

  // Capture read data the cycle after each read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_out    <= '0;
      r_flags_out <= '0;
    end else begin
      case (r_state)
        R_LO:    if (r_op == OP_RTI) r_flags_out <= mem_rdata[3:0];
        R_HI:    r_pc_out[15:0]  <= mem_rdata;
        R_CAP:   r_pc_out[31:16] <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Next-state and memory/handshake decode.
  always_comb begin
    w_next      = r_state;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    done        = 1'b0;
    pc_valid    = 1'b0;
    flags_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          if (w_bad)                 w_next = FIN;
          else if (w_op == OP_RET)   w_next = R_LO;
          else if (w_op == OP_RTI)   w_next = R_FLG;
          else                       w_next = W_HI;
        end
      end
      W_HI: begin
        mem_we    = 1'b1;
        mem_addr  = r_sp;
        mem_wdata = r_pc[31:16];
        w_next    = W_LO;
      end
      W_LO: begin
        mem_we    = 1'b1;
        mem_addr  = r_sp - ADDR_W'(1);
        mem_wdata = r_pc[15:0];
        w_next    = (r_op == OP_INT) ? W_FLG : FIN;
      end
      W_FLG: begin
        mem_we    = 1'b1;
        mem_addr  = r_sp - ADDR_W'(2);
        mem_wdata = {12'h000, r_flags};
        w_next    = FIN;
      end
      R_FLG: begin
        mem_re   = 1'b1;
        mem_addr = r_sp + ADDR_W'(1);
        w_next   = R_LO;
      end
      R_LO: begin
        mem_re   = 1'b1;
        mem_addr = r_sp + ((r_op == OP_RTI) ? ADDR_W'(2) : ADDR_W'(1));
        w_next   = R_HI;
      end
      R_HI: begin
        mem_re   = 1'b1;
        mem_addr = r_sp + ((r_op == OP_RTI) ? ADDR_W'(3) : ADDR_W'(2));
        w_next   = R_CAP;
      end
      R_CAP: begin
        w_next = FIN;
      end
      FIN: begin
        done        = 1'b1;
        pc_valid    = !r_skip && op_is_pop(r_op);
        flags_valid = !r_skip && (r_op == OP_RTI);
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign sp        = r_sp;
  assign pc_out    = r_pc_out;
  assign flags_out = r_flags_out;
  assign fault     = r_fault;

endmodule
